// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: turns host frames into a one-cycle register-write strobe
// and serves register reads over MISO. All SPI pins are oversampled in the CLK domain.
module spi_reg_slave (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCK,
    input  logic       SS_N,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] RD_DATA,
    output logic [6:0] RD_ADDR,
    output logic [7:0] SPI_ADDRESS,
    output logic [7:0] SPI_DATA,
    output logic       RISING_SS,
    output logic       FRAME_ERR
);

    typedef enum logic [1:0] {
        ST_WAIT_HIGH = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2
    } state_t;

    logic       sck_s1_r, sck_s2_r, sck_d_r;
    logic       ss_s1_r, ss_s2_r, ss_d_r;
    logic       mosi_s1_r, mosi_s2_r;
    logic       sck_rise_r, sck_fall_r, ss_rise_r, ss_fall_r;
    logic [1:0] settle_cnt_r;
    state_t     state_r, state_nx_s;
    logic [4:0] bit_cnt_r;
    logic [15:0] shift_in_r;
    logic [7:0] tx_reg_r;
    logic [1:0] rd_pipe_r;
    logic       is_read_r;
    logic [6:0] rd_addr_r;
    logic [7:0] spi_address_r, spi_data_r;
    logic       rising_ss_r, frame_err_r, miso_r, miso_oe_r;

    logic       start_s, shift_s, frame_end_s, wr_done_s, err_s, tx_shift_s, rd_hit_s;

    // Pin synchronisers, edge registers and post-reset settle counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sck_s1_r     <= 1'b0;
            sck_s2_r     <= 1'b0;
            sck_d_r      <= 1'b0;
            ss_s1_r      <= 1'b1;
            ss_s2_r      <= 1'b1;
            ss_d_r       <= 1'b1;
            mosi_s1_r    <= 1'b0;
            mosi_s2_r    <= 1'b0;
            sck_rise_r   <= 1'b0;
            sck_fall_r   <= 1'b0;
            ss_rise_r    <= 1'b0;
            ss_fall_r    <= 1'b0;
            settle_cnt_r <= 2'd0;
        end else begin
            sck_s1_r     <= SCK;
            sck_s2_r     <= sck_s1_r;
            sck_d_r      <= sck_s2_r;
            ss_s1_r      <= SS_N;
            ss_s2_r      <= ss_s1_r;
            ss_d_r       <= ss_s2_r;
            mosi_s1_r    <= MOSI;
            mosi_s2_r    <= mosi_s1_r;
            sck_rise_r   <= sck_s2_r & ~sck_d_r;
            sck_fall_r   <= ~sck_s2_r & sck_d_r;
            ss_rise_r    <= ss_s2_r & ~ss_d_r;
            ss_fall_r    <= ~ss_s2_r & ss_d_r;
            settle_cnt_r <= (settle_cnt_r == 2'd3) ? 2'd3 : settle_cnt_r + 2'd1;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_WAIT_HIGH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; WAIT_HIGH needs the whole sync chain to show SS_N high
    // so a frame already running at reset release never looks like a fresh SS_N fall.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_WAIT_HIGH: begin
                if ((settle_cnt_r == 2'd3) && ss_s1_r && ss_s2_r && ss_d_r) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_HIGH;
                end
            end
            ST_IDLE: begin
                if (ss_fall_r) begin
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ss_rise_r) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            default: state_nx_s = ST_WAIT_HIGH;
        endcase
    end

    // Per-cycle actions; an SS_N rise always wins over a coincident SCK edge.
    always_comb begin
        start_s     = (state_r == ST_IDLE) && ss_fall_r;
        shift_s     = (state_r == ST_SHIFT) && sck_rise_r && !ss_rise_r;
        frame_end_s = (state_r == ST_SHIFT) && ss_rise_r;
        wr_done_s   = frame_end_s && (bit_cnt_r == 5'd16) && !shift_in_r[15];
        err_s       = frame_end_s && (bit_cnt_r != 5'd16);
        rd_hit_s    = shift_s && (bit_cnt_r == 5'd7) && shift_in_r[6];
        tx_shift_s  = (state_r == ST_SHIFT) && sck_fall_r && !ss_rise_r && is_read_r
                      && (bit_cnt_r[4:3] == 2'b01);
    end

    // Frame capture, read pipeline and transmit shifter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt_r  <= 5'd0;
            shift_in_r <= 16'd0;
            tx_reg_r   <= 8'd0;
            rd_pipe_r  <= 2'd0;
            is_read_r  <= 1'b0;
            rd_addr_r  <= 7'd0;
        end else begin
            rd_pipe_r <= {rd_pipe_r[0], rd_hit_s};
            if (start_s) begin
                bit_cnt_r  <= 5'd0;
                shift_in_r <= 16'd0;
            end else if (shift_s) begin
                bit_cnt_r  <= (bit_cnt_r == 5'd31) ? 5'd31 : bit_cnt_r + 5'd1;
                shift_in_r <= {shift_in_r[14:0], mosi_s2_r};
            end
            if (start_s) begin
                is_read_r <= 1'b0;
            end else if (rd_hit_s) begin
                is_read_r <= 1'b1;
            end
            if (rd_hit_s) begin
                rd_addr_r <= {shift_in_r[5:0], mosi_s2_r};
            end
            // RD_DATA follows RD_ADDR one cycle later, so sample two cycles after the update.
            if (start_s) begin
                tx_reg_r <= 8'd0;
            end else if (rd_pipe_r[1]) begin
                tx_reg_r <= RD_DATA;
            end else if (tx_shift_s) begin
                tx_reg_r <= {tx_reg_r[6:0], 1'b0};
            end
        end
    end

    // Registered outputs: write strobe bus, frame error and MISO pad.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            spi_address_r <= 8'd0;
            spi_data_r    <= 8'd0;
            rising_ss_r   <= 1'b0;
            frame_err_r   <= 1'b0;
            miso_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
        end else begin
            rising_ss_r <= wr_done_s;
            frame_err_r <= err_s;
            miso_oe_r   <= (state_nx_s == ST_SHIFT);
            if (wr_done_s) begin
                spi_address_r <= {1'b0, shift_in_r[14:8]};
                spi_data_r    <= shift_in_r[7:0];
            end
            if ((state_nx_s != ST_SHIFT) || start_s) begin
                miso_r <= 1'b0;
            end else if (tx_shift_s) begin
                miso_r <= tx_reg_r[7];
            end
        end
    end

    assign MISO        = miso_r;
    assign MISO_OE     = miso_oe_r;
    assign RD_ADDR     = rd_addr_r;
    assign SPI_ADDRESS = spi_address_r;
    assign SPI_DATA    = spi_data_r;
    assign RISING_SS   = rising_ss_r;
    assign FRAME_ERR   = frame_err_r;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: a host-side driver pushes expected strobes, errors
// and read bytes; pin-level monitors pop and compare as the DUT responds.
module tb_spi_reg_slave;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SCK = 1'b0;
    logic       SS_N = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO, MISO_OE;
    logic [7:0] RD_DATA = 8'h00;
    logic [6:0] RD_ADDR;
    logic [7:0] SPI_ADDRESS, SPI_DATA;
    logic       RISING_SS, FRAME_ERR;

    spi_reg_slave dut (
        .CLK(CLK), .RST(RST), .SCK(SCK), .SS_N(SS_N), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .RD_DATA(RD_DATA), .RD_ADDR(RD_ADDR),
        .SPI_ADDRESS(SPI_ADDRESS), .SPI_DATA(SPI_DATA),
        .RISING_SS(RISING_SS), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Register-file read mux: data valid one cycle after the address.
    logic [7:0] mem [128];
    always @(posedge CLK) RD_DATA <= mem[RD_ADDR];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int miso_viol = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;
    wr_t        wr_q[$];
    int         err_q[$];
    logic [7:0] rd_q[$];

    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic [6:0] m_rd   = 7'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic bit_out(input logic b, input int half);
        MOSI = b;
        clk(half);
        SCK = 1'b1;
        clk(half);
        SCK = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] w, input int nbits, input int half, input int gap);
        if (nbits == 16 && w[15]) rd_q.push_back(mem[w[14:8]]);
        if (nbits >= 8 && w[15]) m_rd = w[14:8];
        SS_N = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bit_out((i < 16) ? w[15-i] : 1'($urandom_range(0, 1)), half);
        end
        clk(half);
        SS_N = 1'b1;
        if (nbits == 16 && !w[15]) begin
            wr_q.push_back('{{1'b0, w[14:8]}, w[7:0], cyc + 4});
            m_addr = {1'b0, w[14:8]};
            m_data = w[7:0];
        end else if (nbits != 16) begin
            err_q.push_back(cyc + 4);
        end
        clk(gap);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_spi_address"}, SPI_ADDRESS, m_addr);
        chk({tag, "_spi_data"}, SPI_DATA, m_data);
        chk({tag, "_rd_addr"}, RD_ADDR, m_rd);
        chk({tag, "_miso_oe"}, MISO_OE, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_spi_address"}, SPI_ADDRESS, 8'h00);
        chk({tag, "_spi_data"}, SPI_DATA, 8'h00);
        chk({tag, "_rd_addr"}, RD_ADDR, 7'h00);
        chk({tag, "_rising_ss"}, RISING_SS, 1'b0);
        chk({tag, "_frame_err"}, FRAME_ERR, 1'b0);
        chk({tag, "_miso"}, MISO, 1'b0);
        chk({tag, "_miso_oe"}, MISO_OE, 1'b0);
    endtask

    // Strobe / error monitor: pops the expected event and checks value and timing.
    always @(negedge CLK) begin
        if (RST) begin
            if (RISING_SS) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_rising_ss", 1, 0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("strobe_address", SPI_ADDRESS, e.a);
                    chk("strobe_data", SPI_DATA, e.d);
                    chk("strobe_cycle", cyc, e.c);
                end
            end
            if (FRAME_ERR) begin
                if (err_q.size() == 0) chk("unexpected_frame_err", 1, 0);
                else chk("frame_err_cycle", cyc, err_q.pop_front());
            end
            if (!MISO_OE && MISO) miso_viol++;
        end
    end

    // Host-side MISO monitor: samples MISO on every SCK rise inside a frame.
    int          mb = 0;
    logic [15:0] mmosi = 16'h0;
    logic [15:0] mmiso = 16'h0;
    always @(negedge SS_N) begin
        mb = 0;
        mmosi = 16'h0;
        mmiso = 16'h0;
    end
    always @(posedge SCK) begin
        if (!SS_N) begin
            if (mb < 16) begin
                mmosi = {mmosi[14:0], MOSI};
                mmiso = {mmiso[14:0], MISO};
            end
            mb++;
        end
    end
    always @(posedge SS_N) begin
        if (mb == 16) begin
            if (mmosi[15]) begin
                if (rd_q.size() == 0) chk("unexpected_read_frame", 1, 0);
                else chk("miso_read_bits", mmiso, {8'h00, rd_q.pop_front()});
            end else begin
                chk("miso_write_bits", mmiso, 16'h0000);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[5] = 8'hA6;

        clk(3);
        check_reset_outputs("reset");
        RST = 1'b1;
        clk(10);

        // Basic write, then read of register 5.
        run_frame(16'h0502, 16, 6, 6);
        check_regs("write_05");
        run_frame(16'h8500, 16, 6, 6);
        check_regs("read_85");

        // Short and long frames must not disturb the last write.
        run_frame(16'h0A33, 15, 5, 6);
        run_frame(16'h0B44, 17, 5, 6);
        check_regs("bad_len");

        // SCK activity with SS_N high is ignored.
        for (int i = 0; i < 8; i++) begin
            SCK = 1'b1;
            clk(4);
            SCK = 1'b0;
            clk(4);
        end
        run_frame(16'h037F, 16, 5, 6);
        check_regs("after_idle_sck");

        // Reset in the middle of a write frame.
        SS_N = 1'b0;
        for (int i = 0; i < 10; i++) bit_out(1'(16'h0A5C >> (15 - i)), 5);
        RST = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        m_addr = 8'h00;
        m_data = 8'h00;
        m_rd   = 7'h00;
        clk(3);
        RST = 1'b1;
        clk(3);
        for (int i = 10; i < 16; i++) bit_out(1'(16'h0A5C >> (15 - i)), 5);
        clk(5);
        SS_N = 1'b1;
        clk(8);
        check_regs("after_mid_reset");
        run_frame(16'h0401, 16, 5, 6);
        check_regs("write_04");

        // Back-to-back writes at minimum timing.
        run_frame(16'h0111, 16, 4, 4);
        run_frame(16'h0222, 16, 4, 4);
        clk(2);
        check_regs("back_to_back");

        // Randomised frames.
        for (int k = 0; k < 30; k++) begin
            logic [15:0] w;
            int nb;
            w = 16'($urandom);
            nb = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(0, 20));
            run_frame(w, nb, int'($urandom_range(4, 6)), int'($urandom_range(4, 8)));
            check_regs("random");
        end

        clk(20);
        chk("pending_strobes", wr_q.size(), 0);
        chk("pending_errors", err_q.size(), 0);
        chk("pending_reads", rd_q.size(), 0);
        chk("miso_while_disabled", miso_viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
